// File: rtl/at_cmd_pkg.sv
// at_cmd_pkg: shared definitions for the AT command transmitter.
//   - cmd_t      : cmd_sel encodings
//   - state_t    : transmitter FSM states
//   - LEN_*      : command lengths with and without the CR/LF terminator
//   - STR_*      : fixed command prefixes, left-justified in 64 bits
//   - nib2ascii  : 4-bit nibble to uppercase hex ASCII
// Optional feature macro: AT_CRLF_EN (append 8'h0D, 8'h0A to every command).
package at_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_AT    = 2'd0,
        CMD_RESET = 2'd1,
        CMD_DISC  = 2'd2,
        CMD_CONN  = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    // Lengths without terminator.
    localparam logic [4:0] LEN_AT    = 5'd2;
    localparam logic [4:0] LEN_RESET = 5'd8;
    localparam logic [4:0] LEN_DISC  = 5'd8;
    localparam logic [4:0] LEN_CONN  = 5'd18;

    // Lengths with CR/LF terminator.
    localparam logic [4:0] LEN_AT_CRLF    = 5'd4;
    localparam logic [4:0] LEN_RESET_CRLF = 5'd10;
    localparam logic [4:0] LEN_DISC_CRLF  = 5'd10;
    localparam logic [4:0] LEN_CONN_CRLF  = 5'd20;

    // Fixed text part of CONNECT; the MAC hex digits follow it.
    localparam logic [4:0] PFX_CONN_LEN = 5'd6;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Prefix text, first character in bits [63:56], unused tail zeroed.
    localparam logic [63:0] STR_AT    = {"AT", 48'h0};
    localparam logic [63:0] STR_RESET = "AT+RESET";
    localparam logic [63:0] STR_DISC  = "AT+DISC?";
    localparam logic [63:0] STR_CONN  = {"AT+CON", 16'h0};

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    // Number of bytes taken from the STR_* prefix table.
    function automatic logic [4:0] prefix_len(input cmd_t c);
        case (c)
            CMD_AT:    return LEN_AT;
            CMD_RESET: return LEN_RESET;
            CMD_DISC:  return LEN_DISC;
            default:   return PFX_CONN_LEN;
        endcase
    endfunction

    // Command body length, excluding any terminator.
    function automatic logic [4:0] base_len(input cmd_t c);
        case (c)
            CMD_AT:    return LEN_AT;
            CMD_RESET: return LEN_RESET;
            CMD_DISC:  return LEN_DISC;
            default:   return LEN_CONN;
        endcase
    endfunction

    // Total number of bytes actually transmitted.
    function automatic logic [4:0] cmd_len(input cmd_t c);
`ifdef AT_CRLF_EN
        case (c)
            CMD_AT:    return LEN_AT_CRLF;
            CMD_RESET: return LEN_RESET_CRLF;
            CMD_DISC:  return LEN_DISC_CRLF;
            default:   return LEN_CONN_CRLF;
        endcase
`else
        return base_len(c);
`endif
    endfunction

endpackage

// File: rtl/at_cmd_rom.sv
// at_cmd_rom: combinational byte lookup for the AT command strings.
// Ports:
//   cmd  : latched command select
//   idx  : byte index within the command (0 = first byte)
//   mac  : latched 48-bit peer address, mac[47:44] sent first
//   data : byte at position idx (8'h00 past the end of the command)
// Optional feature macro: AT_CRLF_EN (CR, LF appended after the body).
module at_cmd_rom
    import at_cmd_pkg::*;
(
    input  cmd_t        cmd,
    input  logic [4:0]  idx,
    input  logic [47:0] mac,
    output logic [7:0]  data
);

    logic [63:0] pfx_str [4];
    logic [7:0]  pfx_b   [4][8];
    logic [7:0]  hex_b   [12];
    logic [1:0]  cmd_i;
    logic [4:0]  plen;
    logic [3:0]  hex_sel;

    assign pfx_str[0] = STR_AT;
    assign pfx_str[1] = STR_RESET;
    assign pfx_str[2] = STR_DISC;
    assign pfx_str[3] = STR_CONN;

    // Unpack each prefix string into a byte table.
    genvar gi, gj;
    generate
        for (gj = 0; gj < 4; gj++) begin : g_pfx_cmd
            for (gi = 0; gi < 8; gi++) begin : g_pfx_byte
                assign pfx_b[gj][gi] = pfx_str[gj][63-8*gi -: 8];
            end
        end
        // MAC address as 12 hex characters, most significant nibble first.
        for (gi = 0; gi < 12; gi++) begin : g_hex
            assign hex_b[gi] = nib2ascii(mac[47-4*gi -: 4]);
        end
    endgenerate

    assign cmd_i = cmd;
    assign plen  = prefix_len(cmd);
    // Hex digit index for CONNECT bytes 6..17; modulo-16 arithmetic is exact there.
    assign hex_sel = idx[3:0] - 4'd6;

`ifdef AT_CRLF_EN
    logic [4:0] blen;
    assign blen = base_len(cmd);
`endif

    always_comb begin
        data = 8'h00;
        if (idx < plen) begin
            data = pfx_b[cmd_i][idx[2:0]];
        end else if (cmd == CMD_CONN && idx < LEN_CONN) begin
            data = hex_b[hex_sel];
        end
`ifdef AT_CRLF_EN
        else if (idx == blen) begin
            data = ASCII_CR;
        end else if (idx == blen + 5'd1) begin
            data = ASCII_LF;
        end
`endif
    end

endmodule

// File: rtl/at_command_tx.sv
// at_command_tx: byte-serial AT command generator feeding a UART transmitter.
// Parameters:
//   GAP_CYCLES : idle cycles inserted after each non-final accepted byte
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : send request, sampled only in IDLE
//   cmd_sel    : command select (AT / RESET / DISC / CONNECT), latched with start
//   mac        : CONNECT peer address, latched with start
//   tx_data    : byte to the UART transmitter
//   tx_valid   : tx_data valid; held with tx_data until tx_ready
//   tx_ready   : transmitter accepts the byte
//   busy       : high from the cycle after start is accepted until done ends
//   done       : one-cycle pulse after the last byte transfer
// Optional feature macro: AT_CRLF_EN (append CR/LF to every command).
module at_command_tx
    import at_cmd_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cmd_sel,
    input  logic [47:0] mac,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t      state_reg, state_next;
    cmd_t        cmd_reg, cmd_next;
    logic [47:0] mac_reg, mac_next;
    logic [4:0]  idx_reg, idx_next;
    logic [4:0]  len_reg, len_next;
    logic [15:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]  rom_byte;

    at_cmd_rom u_rom (
        .cmd  (cmd_reg),
        .idx  (idx_reg),
        .mac  (mac_reg),
        .data (rom_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cmd_reg     <= CMD_AT;
            mac_reg     <= 48'h0;
            idx_reg     <= 5'd0;
            len_reg     <= 5'd0;
            gap_cnt_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            cmd_reg     <= cmd_next;
            mac_reg     <= mac_next;
            idx_reg     <= idx_next;
            len_reg     <= len_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cmd_next     = cmd_reg;
        mac_next     = mac_reg;
        idx_next     = idx_reg;
        len_next     = len_reg;
        gap_cnt_next = gap_cnt_reg;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        done         = 1'b0;
        busy         = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cmd_next   = cmd_t'(cmd_sel);
                    mac_next   = mac;
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                idx_next     = 5'd0;
                len_next     = cmd_len(cmd_reg);
                gap_cnt_next = 16'd0;
                state_next   = ST_SEND;
            end

            ST_SEND: begin
                // Data comes only from latched registers, so it is stable during a stall.
                tx_valid = 1'b1;
                tx_data  = rom_byte;
                if (tx_ready) begin
                    if (idx_reg == len_reg - 5'd1) begin
                        state_next = ST_DONE;
                    end else begin
                        // Index advances now; it is not observed until SEND resumes.
                        idx_next = idx_reg + 5'd1;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_next = 16'd0;
                            state_next   = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_SEND;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_at_command_tx.sv
// tb_at_command_tx: directed, table-driven bench for at_command_tx.
// Two instances: dut (GAP_CYCLES=0) for the vector table and reset test,
// dut_g (GAP_CYCLES=2) for inter-byte gap timing.
// Optional feature macro: AT_CRLF_EN (expected strings gain CR/LF).
module tb_at_command_tx;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  cmd_sel;
    logic [47:0] mac;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic        g_start;
    logic [1:0]  g_cmd_sel;
    logic [47:0] g_mac;
    logic        g_tx_ready;
    logic [7:0]  g_tx_data;
    logic        g_tx_valid;
    logic        g_busy;
    logic        g_done;

    int n_tests = 0;
    int n_fail  = 0;

    at_command_tx #(.GAP_CYCLES(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd_sel  (cmd_sel),
        .mac      (mac),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    at_command_tx #(.GAP_CYCLES(2)) dut_g (
        .clk      (clk),
        .rst      (rst),
        .start    (g_start),
        .cmd_sel  (g_cmd_sel),
        .mac      (g_mac),
        .tx_data  (g_tx_data),
        .tx_valid (g_tx_valid),
        .tx_ready (g_tx_ready),
        .busy     (g_busy),
        .done     (g_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       cmd;
        logic [47:0]      mac;
        int               stall_idx;
        int               stall_len;
        int               repulse_c;
        int               exp_len;
        logic [19:0][7:0] exp_b;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [1:0] c, input logic [47:0] m,
                           input int si, input int sl, input int rc, input string s);
        string t;
        t = s;
`ifdef AT_CRLF_EN
        t = {t, "\r\n"};
`endif
        vecs[i].cmd       = c;
        vecs[i].mac       = m;
        vecs[i].stall_idx = si;
        vecs[i].stall_len = sl;
        vecs[i].repulse_c = rc;
        vecs[i].exp_len   = t.len();
        vecs[i].exp_b     = '0;
        for (int k = 0; k < t.len() && k < 20; k++)
            vecs[i].exp_b[k] = t[k];
    endtask

    // Run one vector on dut. Cycle c=0 is the sample just after the start edge T;
    // sample c corresponds to the value seen by edge T+c+1.
    task automatic run_vec(input int i);
        int  c, nx, ndone, done_c, stall_cnt;
        bit  got_done;
        c = 0; nx = 0; ndone = 0; done_c = -1; stall_cnt = 0; got_done = 0;

        @(negedge clk);
        start    = 1'b1;
        cmd_sel  = vecs[i].cmd;
        mac      = vecs[i].mac;
        tx_ready = 1'b1;
        @(negedge clk);
        // Inputs move after the latch; they must not affect the command.
        start   = 1'b0;
        cmd_sel = ~vecs[i].cmd;
        mac     = ~vecs[i].mac;
        check($sformatf("v%0d busy_after_start", i), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d valid_in_load", i), {31'd0, tx_valid}, 32'd0);

        while (!got_done && c < 200) begin
            if (tx_valid && nx == vecs[i].stall_idx && stall_cnt < vecs[i].stall_len) begin
                tx_ready = 1'b0;
                check($sformatf("v%0d stall%0d_data", i, stall_cnt), {24'd0, tx_data},
                      {24'd0, vecs[i].exp_b[nx]});
                stall_cnt++;
            end else begin
                tx_ready = 1'b1;
            end
            start = (c == vecs[i].repulse_c);
            if (c == vecs[i].repulse_c) cmd_sel = vecs[i].cmd + 2'd1;
            if (done) begin
                ndone++;
                done_c   = c;
                got_done = 1;
            end
            if (tx_valid && tx_ready) begin
                if (nx < 20)
                    check($sformatf("v%0d byte%0d", i, nx), {24'd0, tx_data},
                          {24'd0, vecs[i].exp_b[nx]});
                nx++;
            end
            @(negedge clk);
            c++;
        end
        start    = 1'b0;
        tx_ready = 1'b1;

        check($sformatf("v%0d done_seen", i), {31'd0, got_done}, 32'd1);
        check($sformatf("v%0d byte_count", i), nx, vecs[i].exp_len);
        check($sformatf("v%0d done_cycle", i), done_c, vecs[i].exp_len + 1 + vecs[i].stall_len);
        check($sformatf("v%0d busy_after_done", i), {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check($sformatf("v%0d done_pulses", i), ndone, 1);
        $display("[TB] vec %0d cmd %0d: %0d bytes, done at c=%0d", i, vecs[i].cmd, nx, done_c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nx, c, ndone, last_c, first_c;
        bit got_done;

        set_vec(0, 2'd0, 48'h0,              -1, 0, -1, "AT");
        set_vec(1, 2'd1, 48'h0,               2, 3, -1, "AT+RESET");
        set_vec(2, 2'd2, 48'h0,              -1, 0, -1, "AT+DISC?");
        set_vec(3, 2'd3, 48'h0123_4567_89AB, -1, 0, -1, "AT+CON0123456789AB");
        set_vec(4, 2'd3, 48'hFEDC_BA98_7654, 10, 1, -1, "AT+CONFEDCBA987654");
        set_vec(5, 2'd0, 48'h0,              -1, 0,  1, "AT");
        set_vec(6, 2'd1, 48'h0,              -1, 0,  4, "AT+RESET");

        rst = 1'b1; start = 1'b0; cmd_sel = 2'd0; mac = 48'h0; tx_ready = 1'b0;
        g_start = 1'b0; g_cmd_sel = 2'd0; g_mac = 48'h0; g_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx_data",  {24'd0, tx_data}, 32'h00);
        check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset busy",     {31'd0, busy}, 32'd0);
        check("reset done",     {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++)
            run_vec(i);

        // Reset while CONNECT is presenting byte 5 ("N").
        start = 1'b1; cmd_sel = 2'd3; mac = 48'h0123_4567_89AB; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nx = 0; c = 0;
        while (!(tx_valid && nx == 5) && c < 50) begin
            if (tx_valid) nx++;
            @(negedge clk);
            c++;
        end
        check("rst_mid byte5", {24'd0, tx_data}, 32'h4E);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_mid busy",     {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("rst_mid no_done", ndone, 0);
        $display("[TB] reset mid-CONNECT at byte 5");
        run_vec(0);

        // Gap timing on the GAP_CYCLES=2 instance with AT+DISC?.
        g_start = 1'b1; g_cmd_sel = 2'd2; g_mac = 48'h0; g_tx_ready = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        nx = 0; c = 0; got_done = 0; last_c = -1; first_c = -1;
        while (!got_done && c < 200) begin
            if (g_done) begin
                got_done = 1;
                check("gap done_cycle", c, last_c + 1);
            end
            if (g_tx_valid) begin
                if (nx < 20)
                    check($sformatf("gap byte%0d", nx), {24'd0, g_tx_data}, {24'd0, vecs[2].exp_b[nx]});
                if (nx == 0)
                    first_c = c;
                else
                    check($sformatf("gap spacing%0d", nx), c - last_c, 3);
                last_c = c;
                nx++;
            end
            @(negedge clk);
            c++;
        end
        check("gap done_seen", {31'd0, got_done}, 32'd1);
        check("gap first_xfer", first_c, 1);
        check("gap byte_count", nx, vecs[2].exp_len);
        check("gap busy_after", {31'd0, g_busy}, 32'd0);
        $display("[TB] gap run: %0d bytes, last transfer at c=%0d", nx, last_c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
